// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and sizing constants for the cache-line <-> memory-burst adaptor.
package cacheline_adaptor_pkg;

   localparam int S_LINE  = 256;
   localparam int S_BURST = 64;
   localparam int BEATS   = S_LINE / S_BURST;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } cla_state_t;

endpackage : cacheline_adaptor_pkg

// File: rtl/cacheline_adaptor.sv
// Converts one cache-line read/writeback into a burst of memory beats, sharing a
// single line buffer between read capture and write drive.
module cacheline_adaptor
   import cacheline_adaptor_pkg::*;
#(
   parameter int s_line  = S_LINE,
   parameter int s_burst = S_BURST
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [s_line-1:0]  line_i,
   output logic [s_line-1:0]  line_o,
   input  logic [31:0]        address_i,
   input  logic               read_i,
   input  logic               write_i,
   output logic               resp_o,
   input  logic [s_burst-1:0] burst_i,
   output logic [s_burst-1:0] burst_o,
   output logic [31:0]        address_o,
   output logic               read_o,
   output logic               write_o,
   input  logic               resp_i
);

   localparam int            NB         = s_line / s_burst;
   localparam int            CW         = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [CW-1:0] LAST_BEAT  = CW'(NB - 1);
   localparam logic [31:0]   ALIGN_MASK = ~32'h1F;

   cla_state_t                  state_q, state_d;
   logic [CW-1:0]               count_q, count_d;
   logic [31:0]                 addr_q, addr_d;
   logic [NB-1:0][s_burst-1:0]  buf_q, buf_d;

   // NOTE: the line buffer is reset along with the control state because line_o
   // must read back as zero after reset, even though it is plain data storage.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= '0;
         addr_q  <= '0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         addr_q  <= addr_d;
         buf_q   <= buf_d;
      end
   end

   // NOTE: every next-state signal takes its hold value first so no path through
   // the case statement leaves one unassigned (which would infer a latch).
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      addr_d  = addr_q;
      buf_d   = buf_q;
      unique case (state_q)
         IDLE: begin
            // Writeback has priority when both requests arrive together.
            if (write_i) begin
               state_d = WRITE;
               addr_d  = address_i & ALIGN_MASK;
               buf_d   = line_i;
            end else if (read_i) begin
               state_d = READ;
               addr_d  = address_i & ALIGN_MASK;
            end
         end
         READ: begin
            if (resp_i) begin
               buf_d[count_q] = burst_i;
               count_d        = count_q + CW'(1);
               if (count_q == LAST_BEAT) begin
                  state_d = DONE;
                  count_d = '0;
               end
            end
         end
         WRITE: begin
            if (resp_i) begin
               count_d = count_q + CW'(1);
               if (count_q == LAST_BEAT) begin
                  state_d = DONE;
                  count_d = '0;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decode registered state only, so read_i/write_i never reach them combinationally.
   always_comb begin
      read_o    = (state_q == READ);
      write_o   = (state_q == WRITE);
      resp_o    = (state_q == DONE);
      address_o = addr_q;
      line_o    = buf_q;
      burst_o   = buf_q[count_q];
   end

endmodule : cacheline_adaptor

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: directed table, reset/spurious sequence, random transactions.
module tb_cacheline_adaptor;

   logic         clk = 1'b0;
   logic         rst;
   logic [255:0] line_i, line_o;
   logic [31:0]  address_i, address_o;
   logic         read_i, write_i, resp_o;
   logic [63:0]  burst_i, burst_o;
   logic         read_o, write_o, resp_i;

   int checks   = 0;
   int failures = 0;

   cacheline_adaptor #(.s_line(256), .s_burst(64)) dut (
      .clk       (clk),
      .rst       (rst),
      .line_i    (line_i),
      .line_o    (line_o),
      .address_i (address_i),
      .read_i    (read_i),
      .write_i   (write_i),
      .resp_o    (resp_o),
      .burst_i   (burst_i),
      .burst_o   (burst_o),
      .address_o (address_o),
      .read_o    (read_o),
      .write_o   (write_o),
      .resp_i    (resp_i)
   );

   always #5 clk = ~clk;

   // kind: 0 = read fill, 1 = writeback, 2 = read and write together (write expected)
   typedef struct {
      int           kind;
      logic [31:0]  addr;
      logic [255:0] data;
      logic [31:0]  pat;
      int           plen;
      logic [31:0]  exp_addr;
      int           exp_cyc;
      string        name;
   } vec_t;

   vec_t vecs[4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // Cycle (counting the request edge as edge 0) in which resp_o should be seen:
   // one cycle after the edge that accepts the fourth beat.
   function automatic int resp_cycle(input logic [31:0] pat, input int plen);
      int ones = 0;
      for (int i = 0; i < 64; i++) begin
         if ((i < plen) ? pat[i] : 1'b1) ones++;
         if (ones == 4) return i + 2;
      end
      return -1;
   endfunction

   task automatic run_txn(input int kind, input logic [31:0] addr, input logic [255:0] data,
                          input logic [31:0] pat, input int plen, input logic [31:0] exp_addr,
                          input int exp_cyc, input string nm);
      bit   is_wr = (kind != 0);
      int   cyc, k, i;
      logic r;
      read_i    = (kind != 1);
      write_i   = (kind != 0);
      address_i = addr;
      line_i    = is_wr ? data : {rnd64(), rnd64(), rnd64(), rnd64()};
      tick();
      read_i  = 1'b0;
      write_i = 1'b0;
      line_i  = {rnd64(), rnd64(), rnd64(), rnd64()};
      cyc = 1; k = 0; i = 0;
      check({nm, " address_o"}, 256'(address_o), 256'(exp_addr));
      while (k < 4 && cyc < 40) begin
         r = (i < plen) ? pat[i] : 1'b1;
         i++;
         check({nm, " read_o busy"},  256'(read_o),  256'(!is_wr));
         check({nm, " write_o busy"}, 256'(write_o), 256'(is_wr));
         check({nm, " resp_o busy"},  256'(resp_o),  256'(0));
         if (is_wr) check({nm, " burst_o"}, 256'(burst_o), 256'(data[k*64 +: 64]));
         resp_i  = r;
         burst_i = (r && !is_wr) ? data[k*64 +: 64] : rnd64();
         tick();
         cyc++;
         if (r) k++;
      end
      resp_i = 1'b0;
      check({nm, " beats accepted"}, 256'(k), 256'(4));
      check({nm, " resp_o done"},    256'(resp_o), 256'(1));
      check({nm, " resp cycle"},     256'(cyc), 256'(exp_cyc));
      check({nm, " read_o done"},    256'(read_o), 256'(0));
      check({nm, " write_o done"},   256'(write_o), 256'(0));
      if (!is_wr) check({nm, " line_o"}, line_o, data);
      tick();
      check({nm, " resp_o pulse"}, 256'(resp_o), 256'(0));
      if (!is_wr) check({nm, " line_o held"}, line_o, data);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [255:0] rd_line, wr_line;
      rd_line = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
      wr_line = {{4{16'hDDDD}}, {4{16'hCCCC}}, {4{16'hBBBB}}, {4{16'hAAAA}}};

      vecs[0] = '{0, 32'h0000_1234, rd_line, 32'hFFFF_FFFF, 32, 32'h0000_1220, 5, "read_fill"};
      vecs[1] = '{1, 32'h8000_00FF, wr_line, 32'hFFFF_FFFF, 32, 32'h8000_00E0, 5, "writeback"};
      vecs[2] = '{0, 32'h0000_ABCD, rd_line, 32'b1011001,    7, 32'h0000_ABC0, 8, "stalled_read"};
      vecs[3] = '{2, 32'h1234_567F, wr_line, 32'hFFFF_FFFF, 32, 32'h1234_5660, 5, "rd_wr_both"};

      rst = 1'b1; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
      burst_i = '0; resp_i = 1'b0;
      repeat (3) tick();
      check("reset read_o",    256'(read_o),    256'(0));
      check("reset write_o",   256'(write_o),   256'(0));
      check("reset resp_o",    256'(resp_o),    256'(0));
      check("reset address_o", 256'(address_o), 256'(0));
      check("reset line_o",    line_o,          256'(0));
      check("reset burst_o",   256'(burst_o),   256'(0));
      rst = 1'b0;
      tick();

      foreach (vecs[v])
         run_txn(vecs[v].kind, vecs[v].addr, vecs[v].data, vecs[v].pat, vecs[v].plen,
                 vecs[v].exp_addr, vecs[v].exp_cyc, vecs[v].name);

      // Reset after the second read beat, then spurious resp_i while idle.
      read_i = 1'b1; address_i = 32'h0000_0F00;
      tick();
      read_i = 1'b0;
      for (int b = 0; b < 2; b++) begin
         resp_i = 1'b1; burst_i = rnd64();
         tick();
      end
      resp_i = 1'b0;
      rst    = 1'b1;
      tick();
      check("midreset read_o",    256'(read_o),    256'(0));
      check("midreset resp_o",    256'(resp_o),    256'(0));
      check("midreset line_o",    line_o,          256'(0));
      check("midreset address_o", 256'(address_o), 256'(0));
      rst = 1'b0;
      for (int s = 0; s < 4; s++) begin
         resp_i = 1'b1; burst_i = rnd64();
         tick();
         check("spurious resp_o",  256'(resp_o),  256'(0));
         check("spurious read_o",  256'(read_o),  256'(0));
         check("spurious write_o", 256'(write_o), 256'(0));
      end
      resp_i = 1'b0;
      tick();
      run_txn(0, 32'h0000_1234, rd_line, 32'hFFFF_FFFF, 32, 32'h0000_1220, 5, "read_after_reset");

      for (int t = 0; t < 25; t++) begin
         int           kind;
         logic [31:0]  addr, pat;
         logic [255:0] data;
         kind = int'($urandom_range(0, 2));
         addr = $urandom;
         pat  = $urandom;
         data = {rnd64(), rnd64(), rnd64(), rnd64()};
         run_txn(kind, addr, data, pat, 32, addr & 32'hFFFF_FFE0, resp_cycle(pat, 32), "random");
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_cacheline_adaptor
